// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and constants for the sprite draw scheduler: slot geometry,
// FSM state encoding and position unpacking helpers.
package sched_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int TYPE_W    = 5;
  localparam int POS_W     = 17;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ERASE,
    DRAW,
    DONE
  } sched_state_t;

  function automatic logic [X_W-1:0] pos_x(input logic [POS_W-1:0] pos);
    return pos[POS_W-1 -: X_W];
  endfunction

  function automatic logic [Y_W-1:0] pos_y(input logic [POS_W-1:0] pos);
    return pos[Y_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_slot_store.sv
// Current/previous sprite snapshots with indexed read and an unchanged flag.
// SCHED_SKIP_UNCHANGED_EN enables the unchanged comparison; otherwise it reads 0.
module sched_slot_store
  import sched_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        latch_i,
  input  logic                        commit_i,
  input  logic [NUM_SLOTS*TYPE_W-1:0] obj_type_i,
  input  logic [NUM_SLOTS*POS_W-1:0]  obj_pos_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [TYPE_W-1:0]           prev_type_o,
  output logic [POS_W-1:0]            prev_pos_o,
  output logic [TYPE_W-1:0]           cur_type_o,
  output logic [POS_W-1:0]            cur_pos_o,
  output logic                        unchanged_o
);

  logic [TYPE_W-1:0] cur_type_q  [NUM_SLOTS];
  logic [POS_W-1:0]  cur_pos_q   [NUM_SLOTS];
  logic [TYPE_W-1:0] prev_type_q [NUM_SLOTS];
  logic [POS_W-1:0]  prev_pos_q  [NUM_SLOTS];

  // NOTE: these arrays are reset (unlike a RAM) because an all-zero prev
  // snapshot is what makes the first frame after reset skip every erase.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cur_type_q[i]  <= '0;
        cur_pos_q[i]   <= '0;
        prev_type_q[i] <= '0;
        prev_pos_q[i]  <= '0;
      end
    end else begin
      if (latch_i) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          cur_type_q[i] <= obj_type_i[i*TYPE_W +: TYPE_W];
          cur_pos_q[i]  <= obj_pos_i[i*POS_W +: POS_W];
        end
      end
      if (commit_i) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          prev_type_q[i] <= cur_type_q[i];
          prev_pos_q[i]  <= cur_pos_q[i];
        end
      end
    end
  end

  assign prev_type_o = prev_type_q[rd_idx_i];
  assign prev_pos_o  = prev_pos_q[rd_idx_i];
  assign cur_type_o  = cur_type_q[rd_idx_i];
  assign cur_pos_o   = cur_pos_q[rd_idx_i];

`ifdef SCHED_SKIP_UNCHANGED_EN
  assign unchanged_o = (prev_type_o == cur_type_o) && (prev_pos_o == cur_pos_o) &&
                       (cur_type_o != '0);
`else
  assign unchanged_o = 1'b0;
`endif

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite erase/draw sequencer; sole master of the plotter command port.
// Optional SCHED_SKIP_UNCHANGED_EN suppresses erase+draw for static slots.
module sprite_draw_scheduler
  import sched_pkg::*;
(
  input  logic                        CLOCK_50,
  input  logic                        reset_b,
  input  logic                        frame_start,
  input  logic [NUM_SLOTS*TYPE_W-1:0] obj_type,
  input  logic [NUM_SLOTS*POS_W-1:0]  obj_pos,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_erase,
  output logic [TYPE_W-1:0]           cmd_type,
  output logic [X_W-1:0]              cmd_x,
  output logic [Y_W-1:0]              cmd_y,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              frame_done_q, overrun_q;
  logic              latch, commit, advance, unchanged;
  logic [TYPE_W-1:0] prev_type, cur_type, slot_type;
  logic [POS_W-1:0]  prev_pos, cur_pos, slot_pos;

  sched_slot_store u_store (
    .clk_i       (CLOCK_50),
    .rst_n_i     (reset_b),
    .latch_i     (latch),
    .commit_i    (commit),
    .obj_type_i  (obj_type),
    .obj_pos_i   (obj_pos),
    .rd_idx_i    (idx_q),
    .prev_type_o (prev_type),
    .prev_pos_o  (prev_pos),
    .cur_type_o  (cur_type),
    .cur_pos_o   (cur_pos),
    .unchanged_o (unchanged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLOCK_50 or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= (state_q == DONE);
      overrun_q    <= frame_start && (state_q != IDLE);
    end
  end

  // The command is decoded from held state (index and snapshots only move on
  // a handshake or skip), so it stays stable under backpressure and an
  // asynchronous reset withdraws it immediately.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    latch     = 1'b0;
    commit    = 1'b0;
    advance   = 1'b0;
    slot_type = '0;
    slot_pos  = '0;
    cmd_valid = 1'b0;
    cmd_erase = 1'b0;
    cmd_type  = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    case (state_q)
      IDLE: if (frame_start) state_d = LATCH;
      LATCH: begin
        latch   = 1'b1;
        idx_d   = '0;
        state_d = ERASE;
      end
      ERASE, DRAW: begin
        slot_type = (state_q == ERASE) ? prev_type : cur_type;
        slot_pos  = (state_q == ERASE) ? prev_pos  : cur_pos;
        if (slot_type == '0 || unchanged) begin
          advance = 1'b1;
        end else begin
          cmd_valid = 1'b1;
          cmd_erase = (state_q == ERASE);
          cmd_type  = slot_type;
          cmd_x     = pos_x(slot_pos);
          cmd_y     = pos_y(slot_pos);
          advance   = cmd_ready;
        end
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == ERASE) ? DRAW : DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed self-checking bench for sprite_draw_scheduler: reset, frame timing,
// erase/draw ordering, backpressure, overrun, mid-frame reset, static-slot frames.
module tb_sprite_draw_scheduler;

  typedef struct packed {
    logic       erase;
    logic [4:0] t;
    logic [8:0] x;
    logic [7:0] y;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    int   cyc;
  } rec_t;

  logic         CLOCK_50 = 1'b0;
  logic         reset_b = 1'b0;
  logic         frame_start = 1'b0;
  logic [29:0]  obj_type = '0;
  logic [101:0] obj_pos = '0;
  logic         cmd_ready = 1'b1;
  logic         cmd_valid, cmd_erase, busy, frame_done, overrun;
  logic [4:0]   cmd_type;
  logic [8:0]   cmd_x;
  logic [7:0]   cmd_y;

  int   cyc = 0;
  int   fs_cyc, done_cyc, done_cnt, ovr_cnt;
  int   compared = 0;
  int   mismatched = 0;
  rec_t log_q[$];

  sprite_draw_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .reset_b     (reset_b),
    .frame_start (frame_start),
    .obj_type    (obj_type),
    .obj_pos     (obj_pos),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_erase   (cmd_erase),
    .cmd_type    (cmd_type),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Handshake / pulse monitor, sampled mid-cycle after inputs have settled.
  always @(negedge CLOCK_50) begin
    #1;
    if (reset_b) begin
      if (cmd_valid && cmd_ready)
        log_q.push_back('{cmd: {cmd_erase, cmd_type, cmd_x, cmd_y}, cyc: cyc});
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
    end
  end

  function automatic cmd_t cmd_at(input int k);
    if (k < log_q.size()) return log_q[k].cmd;
    return '1;
  endfunction

  function automatic int cyc_at(input int k);
    if (k < log_q.size()) return log_q[k].cyc - fs_cyc;
    return -1;
  endfunction

  function automatic int erase_count();
    int n = 0;
    foreach (log_q[k]) if (log_q[k].cmd.erase) n++;
    return n;
  endfunction

  task automatic set_slot(input int i, input logic [4:0] t, input logic [16:0] p);
    obj_type[i*5 +: 5]   = t;
    obj_pos[i*17 +: 17]  = p;
  endtask

  task automatic clear_all();
    obj_type = '0;
    obj_pos  = '0;
    log_q.delete();
    done_cnt = 0;
    ovr_cnt  = 0;
    done_cyc = -1;
  endtask

  task automatic start_frame();
    @(negedge CLOCK_50);
    frame_start = 1'b1;
    fs_cyc = cyc;
    @(negedge CLOCK_50);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLOCK_50);
      #2;
      if (done_cnt > 0) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_timeout: frame_done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    compared++;
    if ({cmd_valid, cmd_erase, busy, frame_done, overrun} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {cmd_valid, cmd_erase, busy, frame_done, overrun});
    end
    compared++;
    if ({cmd_type, cmd_x, cmd_y} !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_fields: got type=%h x=%h y=%h required 0", cmd_type, cmd_x, cmd_y);
    end
    reset_b = 1'b1;
    @(negedge CLOCK_50);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_first_frame();
    clear_all();
    set_slot(0, 5'd4, 17'h00A05);
    start_frame();
    wait_done("f1", 40);
    compared++;
    if (erase_count() != 0 || log_q.size() != 1) begin
      mismatched++;
      $display("FAIL f1_count: got %0d cmds (%0d erases) required 1 (0)", log_q.size(), erase_count());
    end
    compared++;
    if (cmd_at(0) !== cmd_t'{1'b0, 5'd4, 9'h00A, 8'h05}) begin
      mismatched++;
      $display("FAIL f1_draw: got %h required %h", cmd_at(0), cmd_t'{1'b0, 5'd4, 9'h00A, 8'h05});
    end
    compared++;
    if (cyc_at(0) != 8) begin
      mismatched++;
      $display("FAIL f1_draw_cycle: got N+%0d required N+8", cyc_at(0));
    end
    compared++;
    if (done_cyc - fs_cyc != 15) begin
      mismatched++;
      $display("FAIL f1_done_cycle: got N+%0d required N+15", done_cyc - fs_cyc);
    end
  endtask

  task automatic test_second_frame();
    clear_all();
    set_slot(0, 5'd4, 17'h04005);
    start_frame();
    wait_done("f2", 40);
    compared++;
    if (log_q.size() != 2) begin
      mismatched++;
      $display("FAIL f2_count: got %0d cmds required 2", log_q.size());
    end
    compared++;
    if (cmd_at(0) !== cmd_t'{1'b1, 5'd4, 9'h00A, 8'h05} || cyc_at(0) != 2) begin
      mismatched++;
      $display("FAIL f2_erase: got %h at N+%0d required %h at N+2",
               cmd_at(0), cyc_at(0), cmd_t'{1'b1, 5'd4, 9'h00A, 8'h05});
    end
    compared++;
    if (cmd_at(1) !== cmd_t'{1'b0, 5'd4, 9'h040, 8'h05} || cyc_at(1) != 8) begin
      mismatched++;
      $display("FAIL f2_draw: got %h at N+%0d required %h at N+8",
               cmd_at(1), cyc_at(1), cmd_t'{1'b0, 5'd4, 9'h040, 8'h05});
    end
    compared++;
    if (done_cyc - fs_cyc != 15) begin
      mismatched++;
      $display("FAIL f2_done_cycle: got N+%0d required N+15", done_cyc - fs_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    clear_all();
    set_slot(0, 5'd4, 17'h08005);
    set_slot(2, 5'd31, 17'h1FFFF);
    start_frame();
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge CLOCK_50);
      if (cmd_valid && !cmd_erase) found = 1'b1;
    end
    cmd_ready = 1'b0;
    compared++;
    if (!found || {cmd_erase, cmd_type, cmd_x, cmd_y} !== cmd_t'{1'b0, 5'd4, 9'h080, 8'h05}) begin
      mismatched++;
      $display("FAIL bp_first_draw: found=%0d got %h required %h", found,
               {cmd_erase, cmd_type, cmd_x, cmd_y}, cmd_t'{1'b0, 5'd4, 9'h080, 8'h05});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_50);
      compared++;
      if (cmd_valid !== 1'b1 ||
          {cmd_erase, cmd_type, cmd_x, cmd_y} !== cmd_t'{1'b0, 5'd4, 9'h080, 8'h05}) begin
        mismatched++;
        $display("FAIL bp_hold_%0d: got valid=%b cmd=%h required valid=1 cmd=%h", k, cmd_valid,
                 {cmd_erase, cmd_type, cmd_x, cmd_y}, cmd_t'{1'b0, 5'd4, 9'h080, 8'h05});
      end
    end
    cmd_ready = 1'b1;
    wait_done("bp", 60);
    compared++;
    if (log_q.size() != 3 || cmd_at(0) !== cmd_t'{1'b1, 5'd4, 9'h040, 8'h05} ||
        cmd_at(1) !== cmd_t'{1'b0, 5'd4, 9'h080, 8'h05}) begin
      mismatched++;
      $display("FAIL bp_handshakes: got %0d cmds [0]=%h [1]=%h required 3 cmds [0]=%h [1]=%h",
               log_q.size(), cmd_at(0), cmd_at(1),
               cmd_t'{1'b1, 5'd4, 9'h040, 8'h05}, cmd_t'{1'b0, 5'd4, 9'h080, 8'h05});
    end
    compared++;
    if (cmd_at(2) !== cmd_t'{1'b0, 5'd31, 9'h1FF, 8'hFF}) begin
      mismatched++;
      $display("FAIL bp_max_pos: got %h required %h", cmd_at(2), cmd_t'{1'b0, 5'd31, 9'h1FF, 8'hFF});
    end
    compared++;
    if (done_cyc - fs_cyc != 20) begin
      mismatched++;
      $display("FAIL bp_done_cycle: got N+%0d required N+20", done_cyc - fs_cyc);
    end
  endtask

  task automatic test_overrun();
    clear_all();
    set_slot(0, 5'd3, 17'h10010);
    set_slot(5, 5'd9, 17'h00100);
    start_frame();
    while (cyc < fs_cyc + 10) @(negedge CLOCK_50);
    frame_start = 1'b1;
    @(negedge CLOCK_50);
    frame_start = 1'b0;
    wait_done("ovr", 40);
    repeat (20) @(negedge CLOCK_50);
    #2;
    compared++;
    if (ovr_cnt != 1) begin
      mismatched++;
      $display("FAIL ovr_pulses: got %0d required 1", ovr_cnt);
    end
    compared++;
    if (done_cnt != 1 || busy !== 1'b0 || log_q.size() != 4) begin
      mismatched++;
      $display("FAIL ovr_extra_frame: got done=%0d busy=%b cmds=%0d required 1/0/4",
               done_cnt, busy, log_q.size());
    end
    compared++;
    if (cmd_at(0) !== cmd_t'{1'b1, 5'd4, 9'h080, 8'h05} ||
        cmd_at(1) !== cmd_t'{1'b1, 5'd31, 9'h1FF, 8'hFF} ||
        cmd_at(2) !== cmd_t'{1'b0, 5'd3, 9'h100, 8'h10} ||
        cmd_at(3) !== cmd_t'{1'b0, 5'd9, 9'h001, 8'h00}) begin
      mismatched++;
      $display("FAIL ovr_cmds: got %h %h %h %h required %h %h %h %h",
               cmd_at(0), cmd_at(1), cmd_at(2), cmd_at(3),
               cmd_t'{1'b1, 5'd4, 9'h080, 8'h05}, cmd_t'{1'b1, 5'd31, 9'h1FF, 8'hFF},
               cmd_t'{1'b0, 5'd3, 9'h100, 8'h10}, cmd_t'{1'b0, 5'd9, 9'h001, 8'h00});
    end
    compared++;
    if (done_cyc - fs_cyc != 15) begin
      mismatched++;
      $display("FAIL ovr_done_cycle: got N+%0d required N+15", done_cyc - fs_cyc);
    end
  endtask

  task automatic test_mid_reset();
    clear_all();
    set_slot(0, 5'd6, 17'h00203);
    start_frame();
    @(negedge CLOCK_50);
    #2;
    compared++;
    if (cmd_valid !== 1'b1 || cmd_erase !== 1'b1) begin
      mismatched++;
      $display("FAIL mr_pre_erase: got valid=%b erase=%b required 1/1", cmd_valid, cmd_erase);
    end
    reset_b = 1'b0;
    #1;
    compared++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mr_async_drop: got valid=%b busy=%b required 0/0", cmd_valid, busy);
    end
    @(negedge CLOCK_50);
    reset_b = 1'b1;
    log_q.delete();
    done_cnt = 0;
    start_frame();
    wait_done("mr", 40);
    compared++;
    if (log_q.size() != 1 || cmd_at(0) !== cmd_t'{1'b0, 5'd6, 9'h002, 8'h03}) begin
      mismatched++;
      $display("FAIL mr_next_frame: got %0d cmds [0]=%h required 1 cmd %h",
               log_q.size(), cmd_at(0), cmd_t'{1'b0, 5'd6, 9'h002, 8'h03});
    end
    compared++;
    if (done_cyc - fs_cyc != 15) begin
      mismatched++;
      $display("FAIL mr_done_cycle: got N+%0d required N+15", done_cyc - fs_cyc);
    end
  endtask

  task automatic test_static_frames();
    int exp_cmds;
    clear_all();
    for (int i = 0; i < 6; i++) set_slot(i, 5'(i + 1), 17'(i * 17'h01111 + 17'h00321));
    start_frame();
    wait_done("st1", 40);
    compared++;
    if (log_q.size() != 7) begin
      mismatched++;
      $display("FAIL st1_count: got %0d cmds required 7", log_q.size());
    end
    log_q.delete();
    done_cnt = 0;
    start_frame();
    wait_done("st2", 40);
`ifdef SCHED_SKIP_UNCHANGED_EN
    exp_cmds = 0;
`else
    exp_cmds = 12;
`endif
    compared++;
    if (log_q.size() != exp_cmds) begin
      mismatched++;
      $display("FAIL st2_count: got %0d cmds required %0d", log_q.size(), exp_cmds);
    end
    compared++;
    if (done_cyc - fs_cyc != 15) begin
      mismatched++;
      $display("FAIL st2_done_cycle: got N+%0d required N+15", done_cyc - fs_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_backpressure();
    test_overrun();
    test_mid_reset();
    test_static_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
